// File: rtl/pipe_skid_reg_pkg.sv
// Shared state encoding and helpers for the pipe_skid_reg skid buffer.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } skid_state_t;

    localparam int OCC_W = 2;

    function automatic logic [OCC_W-1:0] occ_of(input skid_state_t st);
        logic [OCC_W-1:0] occ;
        occ = 2'd0;
        case (st)
            FULL:    occ = 2'd1;
            SKID:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_dff_en_r.sv
// Load-enabled data register with async active-low reset to a parameterised value.
module dff_en_r #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: fully registered handshake outputs, strict FIFO order.
//
// state | meaning
// EMPTY | nothing held, out_valid 0
// FULL  | main register holds the head entry
// SKID  | main holds head, skid holds the next entry; upstream stalled
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    skid_state_t      state;
    skid_state_t      state_nxt;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = in_data;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    main_en   = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (in_valid && out_ready) begin
                    main_en = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end else if (in_valid) begin
                    skid_en   = 1'b1;
                    state_nxt = SKID;
                end
            end
            SKID: begin
                main_d = skid_q;
                if (out_ready) begin
                    main_en   = 1'b1;
                    state_nxt = FULL;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush discards everything, including the word offered this cycle.
        if (flush) begin
            state_nxt = EMPTY;
            main_en   = 1'b0;
            skid_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != SKID);
            out_valid <= (state_nxt != EMPTY);
            occupancy <= occ_of(state_nxt);
        end
    end

    dff_en_r #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_en),
        .d     (main_d),
        .q     (out_data)
    );

    dff_en_r #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: three instances (WIDTH 1/32/64, reset value all-ones) driven in lockstep.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [63:0] din;
    logic        out_ready;

    logic        rdy1, rdy32, rdy64;
    logic        vld1, vld32, vld64;
    logic [0:0]  d1;
    logic [31:0] d32;
    logic [63:0] d64;
    logic [1:0]  occ1, occ32, occ64;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_skid_reg #(.WIDTH(1), .RESET_VAL('1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(din[0:0]),
        .in_ready(rdy1), .out_valid(vld1), .out_data(d1), .out_ready(out_ready), .occupancy(occ1)
    );

    pipe_skid_reg #(.WIDTH(32), .RESET_VAL('1)) dut_w32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(din[31:0]),
        .in_ready(rdy32), .out_valid(vld32), .out_data(d32), .out_ready(out_ready), .occupancy(occ32)
    );

    pipe_skid_reg #(.WIDTH(64), .RESET_VAL('1)) dut_w64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(din),
        .in_ready(rdy64), .out_valid(vld64), .out_data(d64), .out_ready(out_ready), .occupancy(occ64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic v, input logic r, input logic [1:0] o);
        chk({tag, " vld_w1"},  {63'd0, vld1},  {63'd0, v});
        chk({tag, " vld_w32"}, {63'd0, vld32}, {63'd0, v});
        chk({tag, " vld_w64"}, {63'd0, vld64}, {63'd0, v});
        chk({tag, " rdy_w1"},  {63'd0, rdy1},  {63'd0, r});
        chk({tag, " rdy_w32"}, {63'd0, rdy32}, {63'd0, r});
        chk({tag, " rdy_w64"}, {63'd0, rdy64}, {63'd0, r});
        chk({tag, " occ_w1"},  {62'd0, occ1},  {62'd0, o});
        chk({tag, " occ_w32"}, {62'd0, occ32}, {62'd0, o});
        chk({tag, " occ_w64"}, {62'd0, occ64}, {62'd0, o});
    endtask

    task automatic chk_data(input string tag, input logic [63:0] e);
        chk({tag, " data_w1"},  {63'd0, d1},  {63'd0, e[0]});
        chk({tag, " data_w32"}, {32'd0, d32}, {32'd0, e[31:0]});
        chk({tag, " data_w64"}, d64, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = 64'd0;

        // Reset held for three edges
        tick(); tick(); tick();
        chk_ctl("reset", 1'b0, 1'b1, 2'd0);
        chk_data("reset", '1);
        rst_n = 1'b1;

        // Reset-then-stream 1..4 with out_ready high
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = 64'(i);
            tick();
            chk_ctl("stream", 1'b1, 1'b1, 2'd1);
            chk_data("stream", 64'(i));
        end
        in_valid = 1'b0;
        tick();
        chk_ctl("stream_drain", 1'b0, 1'b1, 2'd0);

        // Backpressure: A5, B6 fill, C7 refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din = 64'hA5A5_0000_0000_00A5;
        tick();
        chk_ctl("bp_a5", 1'b1, 1'b1, 2'd1);
        chk_data("bp_a5", 64'hA5A5_0000_0000_00A5);
        din = 64'hB6B6_0000_0000_00B6;
        tick();
        chk_ctl("bp_b6", 1'b1, 1'b0, 2'd2);
        chk_data("bp_b6_head", 64'hA5A5_0000_0000_00A5);
        din = 64'hC7C7_0000_0000_00C7;
        tick();
        chk_ctl("bp_c7_refused", 1'b1, 1'b0, 2'd2);
        chk_data("bp_c7_refused", 64'hA5A5_0000_0000_00A5);
        out_ready = 1'b1;
        tick();
        chk_ctl("bp_drain_b6", 1'b1, 1'b1, 2'd1);
        chk_data("bp_drain_b6", 64'hB6B6_0000_0000_00B6);
        tick();
        chk_ctl("bp_accept_c7", 1'b1, 1'b1, 2'd1);
        chk_data("bp_accept_c7", 64'hC7C7_0000_0000_00C7);
        in_valid = 1'b0;
        tick();
        chk_ctl("bp_empty", 1'b0, 1'b1, 2'd0);

        // Ten cycles of simultaneous push/pop in FULL
        in_valid = 1'b1;
        din = 64'h100;
        tick();
        chk_data("sim_first", 64'h100);
        for (int i = 1; i <= 10; i++) begin
            din = 64'h100 + 64'(i) + (64'(i) << 40);
            tick();
            chk_ctl("sim_full", 1'b1, 1'b1, 2'd1);
            chk_data("sim_full", 64'h100 + 64'(i) + (64'(i) << 40));
        end
        in_valid = 1'b0;
        tick();
        chk_ctl("sim_empty", 1'b0, 1'b1, 2'd0);

        // Flush from SKID with an offer pending
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din = 64'hD1;
        tick();
        din = 64'hD2;
        tick();
        chk_ctl("fl_skid", 1'b1, 1'b0, 2'd2);
        flush = 1'b1;
        din   = 64'hEE;
        tick();
        chk_ctl("fl_flushed", 1'b0, 1'b1, 2'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_ctl("fl_no_ghost", 1'b0, 1'b1, 2'd0);
        chk_data("fl_hold", 64'hD1);
        in_valid = 1'b1;
        din = 64'h33;
        tick();
        chk_ctl("fl_restart", 1'b1, 1'b1, 2'd1);
        chk_data("fl_restart", 64'h33);
        in_valid = 1'b0;
        tick();

        // Async reset between edges while in SKID
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din = 64'h44;
        tick();
        din = 64'h55;
        tick();
        chk_ctl("ar_skid", 1'b1, 1'b0, 2'd2);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_ctl("ar_async", 1'b0, 1'b1, 2'd0);
        chk_data("ar_async", '1);
        tick();
        chk_data("ar_held", '1);
        rst_n = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        din = 64'h66;
        tick();
        chk_ctl("ar_restart", 1'b1, 1'b1, 2'd1);
        chk_data("ar_restart", 64'h66);
        in_valid = 1'b0;
        tick();
        chk_ctl("ar_empty", 1'b0, 1'b1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
